// File: rtl/tape_ear_conditioner.sv
// Purpose : cassette EAR front end: 2-flop synchroniser, optional inversion, pulse-width filter, edge/glitch stats.
// Latency : a held raw level reaches ear_o FILT_CYCLES+1 clk_sys edges after it is first captured.
// Backpr. : none; free-running input stream, outputs are always valid.
//
// Ports:
//   clk_sys        system clock
//   reset_n        asynchronous active-low reset
//   ear_raw_i      raw asynchronous tape pin
//   enable_i       1 = filter runs, 0 = ear_o forced to idle level
//   clear_i        synchronous clear of both statistics counters
//   ear_o          filtered, polarity-corrected EAR level
//   edge_o         one-cycle pulse per accepted ear_o transition
//   activity_o     high while the activity stretch timer is nonzero
//   edge_count_o   accepted transitions, wrapping
//   glitch_count_o rejected pulses, saturating at 255
module tape_ear_conditioner #(
    parameter int FILT_CYCLES = 64,
    parameter bit INVERT      = 1'b1,
    parameter int ACT_BITS    = 21
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ear_raw_i,
    input  logic        enable_i,
    input  logic        clear_i,
    output logic        ear_o,
    output logic        edge_o,
    output logic        activity_o,
    output logic [15:0] edge_count_o,
    output logic [7:0]  glitch_count_o
);
    localparam int                 CW       = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [CW-1:0]      CNT_MAX  = CW'(FILT_CYCLES - 1);
    localparam logic [ACT_BITS-1:0] ACT_LOAD = {ACT_BITS{1'b1}};

    logic                s1_q, s1_d;
    logic                s2_q, s2_d;
    logic                ear_q, ear_d;
    logic                edge_q, edge_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ACT_BITS-1:0] act_q, act_d;
    logic [15:0]         edge_cnt_q, edge_cnt_d;
    logic [7:0]          glitch_cnt_q, glitch_cnt_d;

    logic cand;
    logic glitch_hit;

    assign cand = s2_q ^ INVERT;

    always_comb begin
        s1_d       = ear_raw_i;
        s2_d       = s1_q;
        ear_d      = ear_q;
        cnt_d      = cnt_q;
        edge_d     = 1'b0;
        glitch_hit = 1'b0;

        if (!enable_i) begin
            // Forced return to idle is not a tape transition: no edge pulse.
            ear_d = INVERT;
            cnt_d = '0;
        end else if (cand != ear_q) begin
            if (cnt_q == CNT_MAX) begin
                ear_d  = cand;
                cnt_d  = '0;
                edge_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (cnt_q != '0) begin
            // Candidate fell back before persisting long enough.
            cnt_d      = '0;
            glitch_hit = 1'b1;
        end

        if (edge_q) begin
            act_d = ACT_LOAD;
        end else if (act_q != '0) begin
            act_d = act_q - 1'b1;
        end else begin
            act_d = act_q;
        end

        // Clear wins over a same-cycle increment.
        if (clear_i) begin
            edge_cnt_d   = '0;
            glitch_cnt_d = '0;
        end else begin
            edge_cnt_d   = edge_q ? edge_cnt_q + 1'b1 : edge_cnt_q;
            glitch_cnt_d = (glitch_hit && glitch_cnt_q != 8'hFF) ? glitch_cnt_q + 1'b1 : glitch_cnt_q;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            ear_q        <= INVERT;
            edge_q       <= 1'b0;
            cnt_q        <= '0;
            act_q        <= '0;
            edge_cnt_q   <= '0;
            glitch_cnt_q <= '0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            ear_q        <= ear_d;
            edge_q       <= edge_d;
            cnt_q        <= cnt_d;
            act_q        <= act_d;
            edge_cnt_q   <= edge_cnt_d;
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign ear_o          = ear_q;
    assign edge_o         = edge_q;
    assign activity_o     = (act_q != '0);
    assign edge_count_o   = edge_cnt_q;
    assign glitch_count_o = glitch_cnt_q;

endmodule

// File: tb/tb_tape_ear_conditioner.sv
// Bench for tape_ear_conditioner: instance A (FILT=4, INVERT=1, ACT_BITS=6) is checked every cycle against
// a run-length model plus literal checkpoints; instance B (FILT=1, INVERT=0) toggles the pin every cycle
// to drive the edge counter through its 16-bit wrap.
module tb_tape_ear_conditioner;
    localparam int FILT    = 4;
    localparam bit INV     = 1'b1;
    localparam int ACTB    = 6;
    localparam int ACT_LEN = (1 << ACTB) - 1;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ear_raw_i;
    logic        enable_i;
    logic        clear_i;
    logic        ear_o;
    logic        edge_o;
    logic        activity_o;
    logic [15:0] edge_count_o;
    logic [7:0]  glitch_count_o;

    logic        rst_b_n;
    logic        raw_b;
    logic        ear_b;
    logic        edge_b;
    logic        act_b;
    logic [15:0] ecnt_b;
    logic [7:0]  gcnt_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit done   = 1'b0;
    bit b_done = 1'b0;

    always #5 clk_sys = ~clk_sys;

    tape_ear_conditioner #(.FILT_CYCLES(FILT), .INVERT(INV), .ACT_BITS(ACTB)) dut_a (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ear_raw_i     (ear_raw_i),
        .enable_i      (enable_i),
        .clear_i       (clear_i),
        .ear_o         (ear_o),
        .edge_o        (edge_o),
        .activity_o    (activity_o),
        .edge_count_o  (edge_count_o),
        .glitch_count_o(glitch_count_o)
    );

    tape_ear_conditioner #(.FILT_CYCLES(1), .INVERT(1'b0), .ACT_BITS(2)) dut_b (
        .clk_sys       (clk_sys),
        .reset_n       (rst_b_n),
        .ear_raw_i     (raw_b),
        .enable_i      (1'b1),
        .clear_i       (1'b0),
        .ear_o         (ear_b),
        .edge_o        (edge_b),
        .activity_o    (act_b),
        .edge_count_o  (ecnt_b),
        .glitch_count_o(gcnt_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after a rising edge; outputs are read on falling edges.
    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    task automatic to_neg();
        @(negedge clk_sys);
    endtask

    // ---------------- behavioural model of instance A ----------------
    // The pin is a two-deep delay line; the filter tracks how long the candidate level has
    // disagreed with the output and adopts it once that run reaches FILT cycles.
    int m_s1, m_s2, m_ear, m_run, m_edge, m_ecnt, m_gcnt, m_last_edge;
    bit m_has_edge;
    int m_cyc = 0;

    always @(posedge clk_sys) m_cyc <= m_cyc + 1;

    initial begin
        int cand;
        bit glitch;
        bit prev_edge;
        bit nm_edge;
        m_s1 = 0; m_s2 = 0; m_ear = INV; m_run = 0; m_edge = 0;
        m_ecnt = 0; m_gcnt = 0; m_last_edge = 0; m_has_edge = 0;
        forever begin
            @(posedge clk_sys or negedge reset_n);
            if (reset_n !== 1'b1) begin
                m_s1 = 0; m_s2 = 0; m_ear = INV; m_run = 0; m_edge = 0;
                m_ecnt = 0; m_gcnt = 0; m_has_edge = 0;
            end else begin
                cand      = m_s2 ^ INV;
                prev_edge = (m_edge != 0);
                nm_edge   = 0;
                glitch    = 0;
                if (!enable_i) begin
                    m_ear = INV;
                    m_run = 0;
                end else if (cand != m_ear) begin
                    m_run++;
                    if (m_run == FILT) begin
                        m_ear   = cand;
                        m_run   = 0;
                        nm_edge = 1;
                    end
                end else begin
                    glitch = (m_run > 0);
                    m_run  = 0;
                end
                m_s2 = m_s1;
                m_s1 = ear_raw_i;
                if (clear_i) begin
                    m_ecnt = 0;
                    m_gcnt = 0;
                end else begin
                    if (prev_edge) m_ecnt = (m_ecnt + 1) % 65536;
                    if (glitch && m_gcnt < 255) m_gcnt++;
                end
                if (prev_edge) begin
                    m_has_edge  = 1;
                    m_last_edge = m_cyc;
                end
                m_edge = nm_edge;
            end
        end
    end

    // ---------------- per-cycle compare of instance A ----------------
    initial begin
        logic exp_act;
        forever begin
            @(negedge clk_sys);
            if (done) break;
            exp_act = m_has_edge && ((m_cyc - m_last_edge) >= 1) && ((m_cyc - m_last_edge) <= ACT_LEN);
            chk("cmp ear_o",          ear_o,          m_ear);
            chk("cmp edge_o",         edge_o,         m_edge);
            chk("cmp activity_o",     activity_o,     exp_act);
            chk("cmp edge_count_o",   edge_count_o,   m_ecnt);
            chk("cmp glitch_count_o", glitch_count_o, m_gcnt);
        end
    end

    // ---------------- instance B: 16-bit wrap of edge_count_o ----------------
    initial begin
        rst_b_n = 1'b1;
        raw_b   = 1'b0;
        #1 rst_b_n = 1'b0;
        step(3);
        rst_b_n = 1'b1;
        step(2);
        repeat (65535) begin
            raw_b = ~raw_b;
            step(1);
        end
        step(5);
        to_neg();
        chk("wrap count at 65535", ecnt_b, 32'h0000_FFFF);
        chk("wrap ear level",      ear_b,  1);
        step(1);
        repeat (5) begin
            raw_b = ~raw_b;
            step(1);
        end
        step(5);
        to_neg();
        chk("wrap count after 65540", ecnt_b, 4);
        chk("wrap ear final",         ear_b,  0);
        chk("wrap glitch_count",      gcnt_b, 0);
        b_done = 1'b1;
    end

    // ---------------- directed stimulus for instance A ----------------
    initial begin
        int act_hi;
        bit seen;
        reset_n   = 1'b1;
        ear_raw_i = 1'b0;
        enable_i  = 1'b1;
        clear_i   = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        chk("reset ear_o",          ear_o,          1);
        chk("reset edge_o",         edge_o,         0);
        chk("reset activity_o",     activity_o,     0);
        chk("reset edge_count_o",   edge_count_o,   0);
        chk("reset glitch_count_o", glitch_count_o, 0);
        step(2);
        reset_n = 1'b1;

        // Idle-low pin after reset: no spurious edge.
        step(100);
        chk("idle ear_o",        ear_o,        1);
        chk("idle edge_count_o", edge_count_o, 0);

        // Accepted pulse: raw captured at edge k, ear_o changes at edge k+5.
        ear_raw_i = 1'b1;
        step(5);
        to_neg();
        chk("pulse ear_o at k+4", ear_o,  1);
        chk("pulse edge_o at k+4", edge_o, 0);
        step(1);
        to_neg();
        chk("pulse ear_o at k+5",  ear_o,  0);
        chk("pulse edge_o at k+5", edge_o, 1);
        act_hi = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            to_neg();
            if (activity_o) act_hi++;
        end
        chk("activity stretch length", act_hi,       ACT_LEN);
        chk("pulse edge_count_o",      edge_count_o, 1);
        step(1);
        ear_raw_i = 1'b0;
        step(20);
        to_neg();
        chk("return ear_o",        ear_o,        1);
        chk("return edge_count_o", edge_count_o, 2);
        step(1);
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
        to_neg();
        chk("clear edge_count_o", edge_count_o, 0);

        // Short pulses (3 cycles) are rejected and counted.
        step(1);
        for (int i = 0; i < 5; i++) begin
            ear_raw_i = 1'b1; step(3);
            ear_raw_i = 1'b0; step(10);
        end
        to_neg();
        chk("glitch ear_o",          ear_o,          1);
        chk("glitch edge_count_o",   edge_count_o,   0);
        chk("glitch_count after 5",  glitch_count_o, 5);
        step(1);
        for (int i = 0; i < 300; i++) begin
            ear_raw_i = 1'b1; step(3);
            ear_raw_i = 1'b0; step(10);
        end
        to_neg();
        chk("glitch_count saturates", glitch_count_o, 255);

        // Square wave, then clear coinciding with an edge pulse.
        step(1);
        for (int i = 0; i < 3; i++) begin
            ear_raw_i = 1'b1; step(10);
            ear_raw_i = 1'b0; step(10);
        end
        step(10);
        to_neg();
        chk("square edge_count_o", edge_count_o, 6);
        step(1);
        ear_raw_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            to_neg();
            if (edge_o) seen = 1'b1;
        end
        chk("edge before clear", seen, 1);
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
        to_neg();
        chk("clear beats increment", edge_count_o,   0);
        chk("clear glitch_count_o",  glitch_count_o, 0);

        // Disable while ear_o=0: forced idle without edge; re-enable restarts the filter.
        step(3);
        enable_i = 1'b0;
        step(1);
        to_neg();
        chk("disable ear_o",  ear_o,  1);
        chk("disable edge_o", edge_o, 0);
        step(5);
        to_neg();
        chk("disable edge_count_o", edge_count_o, 0);
        step(1);
        enable_i = 1'b1;
        step(3);
        to_neg();
        chk("reenable ear_o after 3", ear_o, 1);
        step(1);
        to_neg();
        chk("reenable ear_o after 4",  ear_o,  0);
        chk("reenable edge_o after 4", edge_o, 1);
        step(1);
        to_neg();
        chk("reenable edge_count_o", edge_count_o, 1);

        // Reset while the filter has counted 2 cycles of a new level.
        step(1);
        ear_raw_i = 1'b0;
        step(20);
        ear_raw_i = 1'b1;
        step(4);
        reset_n = 1'b0;
        #1;
        chk("midreset ear_o",          ear_o,          1);
        chk("midreset edge_o",         edge_o,         0);
        chk("midreset glitch_count_o", glitch_count_o, 0);
        chk("midreset edge_count_o",   edge_count_o,   0);
        chk("midreset activity_o",     activity_o,     0);
        step(3);
        reset_n = 1'b1;
        // First edge after release captures the pin (k); ear_o changes at k+5.
        step(5);
        to_neg();
        chk("postreset ear_o at k+4", ear_o, 1);
        step(1);
        to_neg();
        chk("postreset ear_o at k+5",  ear_o,          0);
        chk("postreset edge_o at k+5", edge_o,         1);
        chk("postreset glitch_count",  glitch_count_o, 0);
        step(100);

        for (int i = 0; i < 80000 && !b_done; i++) @(posedge clk_sys);
        chk("wrap sequence finished", b_done, 1);

        done = 1'b1;
        repeat (2) @(negedge clk_sys);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
